mem_block_summer: RTL and testbench

- Sequencer that sits directly in front of the 8K x 8 data memory and drives its address, data and load inputs.
- On a start pulse it reads `count` consecutive bytes beginning at `base` and accumulates them into a 16-bit sum.
- Optionally writes the sum back to memory, low byte first, at `dest` and `dest+1`.
- Used as the array-reduction helper for the datapath and as a self-checking loader/reader for memory test programs.

---
 rtl/mem_block_summer.sv | 210 +++++++++++++++++++++
 tb/tb_mem_block_summer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_block_summer.sv
// ---------------------------------------------------------------------------
// mem_block_summer
//
// Sequencer that drives the address, data and load inputs of the 8K x 8 data
// memory. On an accepted start it reads `count` consecutive bytes from `base`,
// accumulates them into a 16-bit sum with a sticky carry-out flag, and can
// optionally write the sum back (low byte at dest, high byte at dest+1).
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   rst        synchronous, active-high reset
//   start      request pulse, only looked at while idle
//   base       first address to read
//   count      number of bytes to sum (0 allowed)
//   dest       write-back address of the low byte
//   wb_en      1 = write the sum back after accumulation
//   busy       high while an operation is in progress
//   done       one-cycle completion pulse
//   sum        accumulated result, held until the next accepted start
//   overflow   sticky carry-out of the accumulator
//   mem_addr   memory address
//   mem_wdata  memory write data
//   mem_ld     memory load strobe (1 = write, 0 = read)
//   mem_rdata  memory read data, valid one cycle after a read address
// ---------------------------------------------------------------------------
module mem_block_summer #(
    parameter int AW = 13,
    parameter int DW = 8,
    parameter int SW = 16,
    parameter int CW = 13
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base,
    input  logic [CW-1:0] count,
    input  logic [AW-1:0] dest,
    input  logic          wb_en,
    output logic          busy,
    output logic          done,
    output logic [SW-1:0] sum,
    output logic          overflow,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_ld,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ACC,
        S_WB_LO,
        S_WB_HI,
        S_DONE
    } state_t;

    state_t        state_q,     state_d;
    logic [AW-1:0] ptr_q,       ptr_d;
    logic [CW-1:0] rem_q,       rem_d;
    logic [AW-1:0] dest_q,      dest_d;
    logic          wb_en_q,     wb_en_d;
    logic [SW-1:0] sum_q,       sum_d;
    logic          overflow_q,  overflow_d;
    logic          busy_q,      busy_d;
    logic          done_q,      done_d;
    logic [AW-1:0] mem_addr_q,  mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          mem_ld_q,    mem_ld_d;

    // One extra bit on the adder captures the carry-out for the sticky flag.
    logic [SW:0]   acc_sum;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the case statements can leave one unassigned and infer a latch.
        state_d     = state_q;
        ptr_d       = ptr_q;
        rem_d       = rem_q;
        dest_d      = dest_q;
        wb_en_d     = wb_en_q;
        sum_d       = sum_q;
        overflow_d  = overflow_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_ld_d    = 1'b0;
        acc_sum     = {1'b0, sum_q} + {{(SW + 1 - DW){1'b0}}, mem_rdata};

        // Next-state and datapath updates.
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ptr_d      = base;
                    rem_d      = count;
                    dest_d     = dest;
                    wb_en_d    = wb_en;
                    sum_d      = '0;
                    overflow_d = 1'b0;
                    if (count != '0) begin
                        state_d = S_ADDR;
                    end else if (wb_en) begin
                        state_d = S_WB_LO;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_ADDR: begin
                state_d = S_ACC;
            end
            S_ACC: begin
                // mem_rdata now holds the byte addressed during S_ADDR.
                sum_d      = acc_sum[SW-1:0];
                overflow_d = overflow_q | acc_sum[SW];
                ptr_d      = ptr_q + AW'(1);
                rem_d      = rem_q - CW'(1);
                if (rem_q != CW'(1)) begin
                    state_d = S_ADDR;
                end else if (wb_en_q) begin
                    state_d = S_WB_LO;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_WB_LO: begin
                state_d = S_WB_HI;
            end
            S_WB_HI: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered, so they are decoded from the state being
        // entered; this keeps them glitch-free and aligned with that state.
        case (state_d)
            S_ADDR, S_ACC: begin
                busy_d     = 1'b1;
                mem_addr_d = ptr_d;
            end
            S_WB_LO: begin
                busy_d      = 1'b1;
                mem_addr_d  = dest_d;
                mem_wdata_d = sum_d[DW-1:0];
                mem_ld_d    = 1'b1;
            end
            S_WB_HI: begin
                busy_d      = 1'b1;
                mem_addr_d  = dest_d + AW'(1);
                mem_wdata_d = sum_d[2*DW-1:DW];
                mem_ld_d    = 1'b1;
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: the reset branch covers every flop, including the latched
        // operands, so an aborted operation leaves nothing stale behind.
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            rem_q       <= '0;
            dest_q      <= '0;
            wb_en_q     <= 1'b0;
            sum_q       <= '0;
            overflow_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_ld_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rem_q       <= rem_d;
            dest_q      <= dest_d;
            wb_en_q     <= wb_en_d;
            sum_q       <= sum_d;
            overflow_q  <= overflow_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_ld_q    <= mem_ld_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sum       = sum_q;
    assign overflow  = overflow_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_ld    = mem_ld_q;

endmodule

// File: tb/tb_mem_block_summer.sv
// ---------------------------------------------------------------------------
// tb_mem_block_summer
//
// Self-checking bench for mem_block_summer. Provides an 8K x 8 synchronous
// memory model, applies a table of operations with expected sum, overflow
// and done latency, and runs hand-written sequences for overflow, start
// during busy/done, and reset mid-operation.
// ---------------------------------------------------------------------------
module tb_mem_block_summer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [12:0] base;
    logic [12:0] count;
    logic [12:0] dest;
    logic        wb_en;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        overflow;
    logic [12:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ld;
    logic [7:0]  mem_rdata;

    int total = 0;
    int bad   = 0;
    int ld_cycles = 0;

    typedef struct {
        logic [12:0] base;
        logic [12:0] count;
        logic [12:0] dest;
        logic        wb_en;
        logic [15:0] exp_sum;
        logic        exp_ovf;
        int          exp_lat;
    } vec_t;

    vec_t sb[$];
    vec_t vecs[5];

    mem_block_summer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base      (base),
        .count     (count),
        .dest      (dest),
        .wb_en     (wb_en),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .overflow  (overflow),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ld    (mem_ld),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: synchronous read, data valid the cycle after the address.
    // Backdoor preloads go through the same process, one byte per cycle.
    logic [7:0]  mem [8192];
    logic        pk_en = 1'b0;
    logic [12:0] pk_a  = '0;
    logic [7:0]  pk_d  = '0;

    always @(posedge clk) begin
        if (pk_en) begin
            mem[pk_a] <= pk_d;
        end else if (mem_ld === 1'b1) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr];
        if (mem_ld === 1'b1) ld_cycles++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic poke(input logic [12:0] a, input logic [7:0] d);
        @(negedge clk);
        pk_en = 1'b1;
        pk_a  = a;
        pk_d  = d;
        @(negedge clk);
        pk_en = 1'b0;
    endtask

    // mode: 0 plain, 1 extra start pulse mid-operation, 2 start held in DONE.
    task automatic run_op(input vec_t v, input int mode, input string tag);
        int   lat;
        int   ld0;
        int   bound;
        bit   seen;
        vec_t e;
        logic [12:0] d1;
        @(negedge clk);
        base  = v.base;
        count = v.count;
        dest  = v.dest;
        wb_en = v.wb_en;
        start = 1'b1;
        sb.push_back(v);
        ld0   = ld_cycles;
        bound = 2 * int'(v.count) + 10;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 0;
        seen  = done;
        while (!seen && lat < bound) begin
            if (mode == 1 && lat == 3) begin
                base  = 13'd8190;
                count = 13'd4;
                dest  = 13'd100;
                wb_en = 1'b1;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
            seen = done;
        end
        start = 1'b0;
        e = sb.pop_front();
        if (!seen) begin
            check({tag, "_timeout"}, 32'(seen), 32'd1);
        end else begin
            check({tag, "_sum"}, 32'(sum), 32'(e.exp_sum));
            check({tag, "_ovf"}, 32'(overflow), 32'(e.exp_ovf));
            check({tag, "_lat"}, 32'(lat), 32'(e.exp_lat));
            check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
            check({tag, "_ld_cycles"}, 32'(ld_cycles - ld0), e.wb_en ? 32'd2 : 32'd0);
            if (mode == 2) begin
                base  = 13'd1000;
                count = 13'd10;
                wb_en = 1'b0;
                start = 1'b1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            check({tag, "_done_pulse"}, 32'(done), 32'd0);
            check({tag, "_busy_after"}, 32'(busy), 32'd0);
            if (mode == 2) begin
                @(posedge clk);
                #1;
                check({tag, "_start_in_done_ignored"}, 32'(busy), 32'd0);
            end
            if (e.wb_en) begin
                d1 = e.dest + 13'd1;
                check({tag, "_wb_lo"}, 32'(mem[e.dest]), 32'(e.exp_sum[7:0]));
                check({tag, "_wb_hi"}, 32'(mem[d1]), 32'(e.exp_sum[15:8]));
            end
        end
    endtask

    initial begin
        logic [7:0] blk [10];
        int ld0;

        blk = '{8'd150, 8'd200, 8'd116, 8'd212, 8'd5, 8'd4, 8'd3, 8'd0, 8'd1, 8'd9};

        // {base, count, dest, wb_en, sum, overflow, done latency}
        vecs[0] = '{13'd1000, 13'd10, 13'd0,    1'b0, 16'd700, 1'b0, 20};
        vecs[1] = '{13'd1000, 13'd10, 13'd2000, 1'b1, 16'd700, 1'b0, 22};
        vecs[2] = '{13'd8190, 13'd4,  13'd8191, 1'b1, 16'd38,  1'b0, 10};
        vecs[3] = '{13'd0,    13'd0,  13'd50,   1'b1, 16'd0,   1'b0, 2};
        vecs[4] = '{13'd1000, 13'd0,  13'd0,    1'b0, 16'd0,   1'b0, 0};

        rst   = 1'b1;
        start = 1'b0;
        base  = '0;
        count = '0;
        dest  = '0;
        wb_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",     32'(busy),      32'd0);
        check("rst_done",     32'(done),      32'd0);
        check("rst_sum",      32'(sum),       32'd0);
        check("rst_overflow", 32'(overflow),  32'd0);
        check("rst_mem_addr", 32'(mem_addr),  32'd0);
        check("rst_wdata",    32'(mem_wdata), 32'd0);
        check("rst_mem_ld",   32'(mem_ld),    32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) poke(13'(1000 + i), blk[i]);
        poke(13'd8190, 8'd1);
        poke(13'd8191, 8'd2);
        poke(13'd0,    8'd20);
        poke(13'd1,    8'd15);
        poke(13'd50,   8'hAA);
        poke(13'd51,   8'hBB);

        for (int i = 0; i < 5; i++) begin
            run_op(vecs[i], 0, $sformatf("vec%0d", i));
        end

        // Extra start while busy must not disturb the running operation.
        run_op(vecs[0], 1, "start_busy");

        // Overflow: 300 x 0xFF = 76500 -> 10964 with carry-out.
        for (int i = 0; i < 300; i++) poke(13'(i), 8'hFF);
        poke(13'd3000, 8'h05);
        run_op('{13'd0, 13'd300, 13'd0, 1'b0, 16'd10964, 1'b1, 600}, 0, "ovf");
        repeat (5) @(posedge clk);
        #1;
        check("ovf_sum_hold", 32'(sum),      32'd10964);
        check("ovf_flag_hold", 32'(overflow), 32'd1);
        // Next accepted start clears the sticky flag; start held into DONE is ignored.
        run_op('{13'd3000, 13'd1, 13'd0, 1'b0, 16'd5, 1'b0, 2}, 2, "ovf_clear");

        // Reset during ACC of element 3 aborts with no write-back.
        poke(13'd4000, 8'h11);
        poke(13'd4001, 8'h22);
        @(negedge clk);
        base  = 13'd1000;
        count = 13'd10;
        dest  = 13'd4000;
        wb_en = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("abort_busy_before", 32'(busy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy",     32'(busy),      32'd0);
        check("abort_done",     32'(done),      32'd0);
        check("abort_mem_ld",   32'(mem_ld),    32'd0);
        check("abort_sum",      32'(sum),       32'd0);
        check("abort_overflow", 32'(overflow),  32'd0);
        check("abort_mem_addr", 32'(mem_addr),  32'd0);
        check("abort_wdata",    32'(mem_wdata), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ld0 = ld_cycles;
        repeat (30) @(posedge clk);
        #1;
        check("abort_no_writes", 32'(ld_cycles - ld0), 32'd0);
        check("abort_dest_lo",   32'(mem[4000]),       32'h11);
        check("abort_dest_hi",   32'(mem[4001]),       32'h22);
        check("abort_idle",      32'(busy),            32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
